// File: rtl/cpu_defs_pkg.sv
// Shared CPU control definitions: opcodes, T-step state encoding and the
// control strobe bundle produced by the decoder.
package cpu_defs_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;

  localparam logic [4:0] LD      = 5'b00000;
  localparam logic [4:0] LDI     = 5'b00001;
  localparam logic [4:0] ST      = 5'b00010;
  localparam logic [4:0] ADD     = 5'b00011;
  localparam logic [4:0] SUB     = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ROR     = 5'b00111;
  localparam logic [4:0] ROL     = 5'b01000;
  localparam logic [4:0] SHR     = 5'b01001;
  localparam logic [4:0] SHRA    = 5'b01010;
  localparam logic [4:0] SHL     = 5'b01011;
  localparam logic [4:0] ADDI    = 5'b01100;
  localparam logic [4:0] ANDI    = 5'b01101;
  localparam logic [4:0] ORI     = 5'b01110;
  localparam logic [4:0] DIV     = 5'b01111;
  localparam logic [4:0] MUL     = 5'b10000;
  localparam logic [4:0] MFHI    = 5'b11000;
  localparam logic [4:0] MFLO    = 5'b11001;
  localparam logic [4:0] NOP     = 5'b11010;
  localparam logic [4:0] HALT    = 5'b11011;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       zhigh_out;
    logic       zlow_out;
    logic       hi_out;
    logic       lo_out;
    logic       mdr_out;
    logic       c_out;
    logic       ba_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       mar_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       hi_in;
    logic       lo_in;
    logic       zhi_in;
    logic       zlo_in;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic [4:0] operation;
    logic       illegal_op;
  } ctl_t;

  function automatic logic is_r_alu(input logic [4:0] op);
    return op inside {ADD, SUB, ALU_AND, ALU_OR, ROR, ROL, SHR, SHRA, SHL};
  endfunction

  function automatic logic is_i_alu(input logic [4:0] op);
    return op inside {ADDI, ANDI, ORI};
  endfunction

  // Opcodes that form a base+displacement value in T3/T4.
  function automatic logic is_addr_op(input logic [4:0] op);
    return op inside {LD, LDI, ST};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {DIV, MUL};
  endfunction

endpackage

// File: rtl/control_decode.sv
// Moore decode of T-step state plus latched opcode into the datapath
// control strobe bundle.
module control_decode
  import cpu_defs_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] op,
  output ctl_t       ctl
);

  // Strobe mapping for every state; anything not named stays low.
  always_comb begin
    ctl = '0;
    case (state)
      S_T0: begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.zlo_in = 1'b1;
      end
      S_T1: begin
        ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
      end
      S_T3: begin
        if (is_r_alu(op) || is_i_alu(op)) begin
          ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
        end else if (is_addr_op(op)) begin
          ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
        end else if (is_muldiv(op)) begin
          ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
        end else if (op == MFHI) begin
          ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
        end else if (op == MFLO) begin
          ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
        end else if (op == NOP || op == HALT) begin
          ctl.illegal_op = 1'b0;
        end else begin
          ctl.illegal_op = 1'b1;
        end
      end
      S_T4: begin
        if (is_r_alu(op)) begin
          ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.operation = op; ctl.zlo_in = 1'b1;
        end else if (is_i_alu(op)) begin
          ctl.c_out = 1'b1; ctl.operation = op; ctl.zlo_in = 1'b1;
        end else if (is_addr_op(op)) begin
          ctl.c_out = 1'b1; ctl.operation = OP_ADD; ctl.zlo_in = 1'b1;
        end else if (is_muldiv(op)) begin
          ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.operation = op;
          ctl.zlo_in = 1'b1; ctl.zhi_in = 1'b1;
        end else begin
          ctl.operation = 5'b00000;
        end
      end
      S_T5: begin
        if (is_r_alu(op) || is_i_alu(op) || op == LDI) begin
          ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
        end else if (op == LD || op == ST) begin
          ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1;
        end else if (is_muldiv(op)) begin
          ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1;
        end else begin
          ctl.zlow_out = 1'b0;
        end
      end
      S_T6: begin
        if (op == LD) begin
          ctl.read = 1'b1; ctl.mdr_in = 1'b1;
        end else if (op == ST) begin
          ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1;
        end else if (is_muldiv(op)) begin
          ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1;
        end else begin
          ctl.read = 1'b0;
        end
      end
      S_T7: begin
        if (op == LD) begin
          ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
        end else if (op == ST) begin
          ctl.write = 1'b1;
        end else begin
          ctl.write = 1'b0;
        end
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer_checker.sv
// Invariant checks on the sequencer outputs: the shared bus has at most one
// driver in any cycle.
module control_sequencer_checker (
  input logic       clk,
  input logic       clr,
  input logic [7:0] bus_sel
);

  a_bus_onehot0: assert property (@(posedge clk) disable iff (!clr) $onehot0(bus_sel));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer: T-step FSM, opcode latch and
// memory-wait watchdog driving the datapath control lines.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] ir_op,
  input  logic       mem_rdy,
  output logic       PCout,
  output logic       ZHighout,
  output logic       Zlowout,
  output logic       HIout,
  output logic       LOout,
  output logic       MDRout,
  output logic       Cout,
  output logic       BAout,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       MARin,
  output logic       PCin,
  output logic       MDRin,
  output logic       IRin,
  output logic       Yin,
  output logic       HIin,
  output logic       LOin,
  output logic       ZHIin,
  output logic       ZLOin,
  output logic       IncPC,
  output logic       Read,
  output logic       Write,
  output logic [4:0] operation,
  output logic       run,
  output logic       mem_err,
  output logic       illegal_op
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_t          state_r;
  state_t          nxt_s;
  state_t          state_s;
  logic [4:0]      op_r;
  logic [CW-1:0]   wait_cnt_r;
  logic            mem_err_r;
  logic            wait_s;
  logic            timeout_s;
  ctl_t            ctl_s;

  control_decode u_decode (
    .state (state_r),
    .op    (op_r),
    .ctl   (ctl_s)
  );

  // Read/Write strobes mark exactly the states that stall on memory.
  assign wait_s    = ctl_s.read | ctl_s.write;
  assign timeout_s = wait_s & ~mem_rdy & (wait_cnt_r == CW'(MEM_WAIT_MAX));

  // Step sequencing assuming the current access (if any) completes.
  always_comb begin
    nxt_s = S_T0;
    case (state_r)
      S_T0: nxt_s = S_T1;
      S_T1: nxt_s = S_T2;
      S_T2: nxt_s = S_T3;
      S_T3: begin
        if (op_r == HALT) begin
          nxt_s = S_HALT;
        end else if (is_r_alu(op_r) || is_i_alu(op_r) || is_addr_op(op_r) || is_muldiv(op_r)) begin
          nxt_s = S_T4;
        end else begin
          nxt_s = S_T0;
        end
      end
      S_T4: nxt_s = S_T5;
      S_T5: begin
        if (op_r == LD || op_r == ST || is_muldiv(op_r)) begin
          nxt_s = S_T6;
        end else begin
          nxt_s = S_T0;
        end
      end
      S_T6: begin
        if (op_r == LD || op_r == ST) begin
          nxt_s = S_T7;
        end else begin
          nxt_s = S_T0;
        end
      end
      S_T7:   nxt_s = S_T0;
      S_HALT: nxt_s = S_HALT;
      default: nxt_s = S_T0;
    endcase
  end

  // Memory stall overrides sequencing; a ready on the limit cycle still wins.
  always_comb begin
    state_s = nxt_s;
    if (wait_s && !mem_rdy) begin
      state_s = timeout_s ? S_HALT : state_r;
    end else begin
      state_s = nxt_s;
    end
  end

  // State, opcode latch, wait counter and sticky bus error.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r    <= S_T0;
      op_r       <= 5'b00000;
      wait_cnt_r <= '0;
      mem_err_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == S_T2) begin
        op_r <= ir_op;
      end
      if (wait_s && !mem_rdy && !timeout_s) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end
    end
  end

  assign PCout      = ctl_s.pc_out;
  assign ZHighout   = ctl_s.zhigh_out;
  assign Zlowout    = ctl_s.zlow_out;
  assign HIout      = ctl_s.hi_out;
  assign LOout      = ctl_s.lo_out;
  assign MDRout     = ctl_s.mdr_out;
  assign Cout       = ctl_s.c_out;
  assign BAout      = ctl_s.ba_out;
  assign Gra        = ctl_s.gra;
  assign Grb        = ctl_s.grb;
  assign Grc        = ctl_s.grc;
  assign Rin        = ctl_s.r_in;
  assign Rout       = ctl_s.r_out;
  assign MARin      = ctl_s.mar_in;
  assign PCin       = ctl_s.pc_in;
  assign MDRin      = ctl_s.mdr_in;
  assign IRin       = ctl_s.ir_in;
  assign Yin        = ctl_s.y_in;
  assign HIin       = ctl_s.hi_in;
  assign LOin       = ctl_s.lo_in;
  assign ZHIin      = ctl_s.zhi_in;
  assign ZLOin      = ctl_s.zlo_in;
  assign IncPC      = ctl_s.inc_pc;
  assign Read       = ctl_s.read;
  assign Write      = ctl_s.write;
  assign operation  = ctl_s.operation;
  assign illegal_op = ctl_s.illegal_op;
  assign run        = (state_r != S_HALT);
  assign mem_err    = mem_err_r;

  control_sequencer_checker u_checker (
    .clk     (clk),
    .clr     (clr),
    .bus_sel ({ctl_s.pc_out, ctl_s.zhigh_out, ctl_s.zlow_out, ctl_s.hi_out,
               ctl_s.lo_out, ctl_s.mdr_out, ctl_s.c_out, ctl_s.ba_out})
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: each driven cycle pushes the expected output snapshot,
// the negedge monitor pops and compares it against the DUT.
module tb_control_sequencer;

  typedef struct packed {
    logic illegal, err, run;
    logic [4:0] op;
    logic write, read, inc_pc, zlo_in, zhi_in, lo_in, hi_in, y_in, ir_in, mdr_in;
    logic pc_in, mar_in, r_out, r_in, grc, grb, gra, ba_out, c_out, mdr_out;
    logic lo_out, hi_out, zlow_out, zhigh_out, pc_out;
  } obs_t;

  logic clk, clr, mem_rdy;
  logic [4:0] ir_op;
  logic PCout, ZHighout, Zlowout, HIout, LOout, MDRout, Cout, BAout;
  logic Gra, Grb, Grc, Rin, Rout, MARin, PCin, MDRin, IRin, Yin;
  logic HIin, LOin, ZHIin, ZLOin, IncPC, Read, Write, run, mem_err, illegal_op;
  logic [4:0] operation;

  obs_t obs_s;
  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic err_m = 1'b0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir_op(ir_op), .mem_rdy(mem_rdy),
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .HIout(HIout),
    .LOout(LOout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .operation(operation), .run(run),
    .mem_err(mem_err), .illegal_op(illegal_op)
  );

  assign obs_s = {illegal_op, mem_err, run, operation, Write, Read, IncPC, ZLOin, ZHIin,
                  LOin, HIin, Yin, IRin, MDRin, PCin, MARin, Rout, Rin, Grc, Grb, Gra,
                  BAout, Cout, MDRout, LOout, HIout, Zlowout, ZHighout, PCout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs of T-step t (8 = halted) for opcode op.
  function automatic obs_t expect_out(input int t, input logic [4:0] op, input logic err);
    obs_t e;
    logic r, i, am, md;
    e  = '0;
    r  = (op >= 5'd3) && (op <= 5'd11);
    i  = (op >= 5'd12) && (op <= 5'd14);
    am = (op <= 5'd2);
    md = (op == 5'd15) || (op == 5'd16);
    e.run = (t != 8);
    e.err = err;
    case (t)
      0: begin e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.zlo_in = 1'b1; end
      1: begin e.zlow_out = 1'b1; e.pc_in = 1'b1; e.read = 1'b1; e.mdr_in = 1'b1; end
      2: begin e.mdr_out = 1'b1; e.ir_in = 1'b1; end
      3: begin
        if (r || i) begin e.grb = 1'b1; e.r_out = 1'b1; e.y_in = 1'b1; end
        else if (am) begin e.grb = 1'b1; e.ba_out = 1'b1; e.y_in = 1'b1; end
        else if (md) begin e.gra = 1'b1; e.r_out = 1'b1; e.y_in = 1'b1; end
        else if (op == 5'b11000) begin e.hi_out = 1'b1; e.gra = 1'b1; e.r_in = 1'b1; end
        else if (op == 5'b11001) begin e.lo_out = 1'b1; e.gra = 1'b1; e.r_in = 1'b1; end
        else if (op != 5'b11010 && op != 5'b11011) e.illegal = 1'b1;
      end
      4: begin
        if (r) begin e.grc = 1'b1; e.r_out = 1'b1; e.op = op; e.zlo_in = 1'b1; end
        else if (i) begin e.c_out = 1'b1; e.op = op; e.zlo_in = 1'b1; end
        else if (am) begin e.c_out = 1'b1; e.op = 5'b00011; e.zlo_in = 1'b1; end
        else if (md) begin
          e.grb = 1'b1; e.r_out = 1'b1; e.op = op; e.zlo_in = 1'b1; e.zhi_in = 1'b1;
        end
      end
      5: begin
        if (r || i || op == 5'b00001) begin e.zlow_out = 1'b1; e.gra = 1'b1; e.r_in = 1'b1; end
        else if (am) begin e.zlow_out = 1'b1; e.mar_in = 1'b1; end
        else if (md) begin e.zlow_out = 1'b1; e.lo_in = 1'b1; end
      end
      6: begin
        if (op == 5'b00000) begin e.read = 1'b1; e.mdr_in = 1'b1; end
        else if (op == 5'b00010) begin e.gra = 1'b1; e.r_out = 1'b1; e.mdr_in = 1'b1; end
        else if (md) begin e.zhigh_out = 1'b1; e.hi_in = 1'b1; end
      end
      7: begin
        if (op == 5'b00000) begin e.mdr_out = 1'b1; e.gra = 1'b1; e.r_in = 1'b1; end
        else if (op == 5'b00010) e.write = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Holds clr low across two edges; the second edge is the next task's first cycle.
  task automatic do_reset();
    clr   = 1'b0;
    ir_op = 5'($urandom);
    @(posedge clk); #2;
    err_m = 1'b0;
    exp_q.push_back(expect_out(0, 5'b0, 1'b0));
  endtask

  // Runs one instruction; waits add mem_rdy=0 cycles, stuck never completes the access.
  task automatic do_instr(input logic [4:0] op, input int t1_wait, input int mem_wait,
                          input bit stuck, input int max_cyc);
    int seq[$];
    bit wt[$];
    bit is_wait;
    seq.push_back(0); wt.push_back(1'b0);
    for (int k = 0; k < t1_wait; k++) begin seq.push_back(1); wt.push_back(1'b1); end
    seq.push_back(1); wt.push_back(1'b0);
    seq.push_back(2); wt.push_back(1'b0);
    seq.push_back(3); wt.push_back(1'b0);
    if (op == 5'b11011) begin
      for (int k = 0; k < 4; k++) begin seq.push_back(8); wt.push_back(1'b0); end
    end else if (op == 5'b00000) begin
      seq.push_back(4); wt.push_back(1'b0);
      seq.push_back(5); wt.push_back(1'b0);
      for (int k = 0; k < mem_wait; k++) begin seq.push_back(6); wt.push_back(1'b1); end
      seq.push_back(6); wt.push_back(1'b0);
      seq.push_back(7); wt.push_back(1'b0);
    end else if (op == 5'b00010) begin
      seq.push_back(4); wt.push_back(1'b0);
      seq.push_back(5); wt.push_back(1'b0);
      seq.push_back(6); wt.push_back(1'b0);
      if (stuck) begin
        for (int k = 0; k < 16; k++) begin seq.push_back(7); wt.push_back(1'b1); end
        for (int k = 0; k < 4; k++) begin seq.push_back(8); wt.push_back(1'b0); end
      end else begin
        for (int k = 0; k < mem_wait; k++) begin seq.push_back(7); wt.push_back(1'b1); end
        seq.push_back(7); wt.push_back(1'b0);
      end
    end else if ((op >= 5'd1 && op <= 5'd14)) begin
      seq.push_back(4); wt.push_back(1'b0);
      seq.push_back(5); wt.push_back(1'b0);
    end else if (op == 5'd15 || op == 5'd16) begin
      seq.push_back(4); wt.push_back(1'b0);
      seq.push_back(5); wt.push_back(1'b0);
      seq.push_back(6); wt.push_back(1'b0);
    end
    for (int k = 0; k < seq.size() && (max_cyc == 0 || k < max_cyc); k++) begin
      @(posedge clk); #2;
      clr = 1'b1;
      if (seq[k] == 8 && stuck) err_m = 1'b1;
      exp_q.push_back(expect_out(seq[k], op, err_m));
      ir_op = (seq[k] == 2) ? op : 5'($urandom);
      is_wait = (seq[k] == 1) || (seq[k] == 6 && op == 5'b00000) || (seq[k] == 7 && op == 5'b00010);
      mem_rdy = is_wait ? !wt[k] : 1'($urandom);
    end
  endtask

  // Compare each cycle's outputs mid-cycle against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) check($sformatf("cyc%0d", cyc), 64'(obs_s), 64'(exp_q.pop_front()));
  end

  initial begin
    clr = 1'b0; mem_rdy = 1'b1; ir_op = 5'b11010;
    do_reset();
    do_instr(5'b11010, 0, 0, 1'b0, 0);   // nop: fetch + 1
    do_instr(5'b00011, 0, 0, 1'b0, 0);   // add
    do_instr(5'b00100, 2, 0, 1'b0, 0);   // sub with fetch wait
    do_instr(5'b01011, 0, 0, 1'b0, 0);   // shl
    do_instr(5'b01100, 0, 0, 1'b0, 0);   // addi
    do_instr(5'b01110, 0, 0, 1'b0, 0);   // ori
    do_instr(5'b00001, 0, 0, 1'b0, 0);   // ldi
    do_instr(5'b00000, 0, 3, 1'b0, 0);   // ld, 3 wait cycles
    do_instr(5'b00000, 0, 15, 1'b0, 0);  // ld, ready on the limit cycle
    do_instr(5'b00010, 0, 0, 1'b0, 0);   // st
    do_instr(5'b10000, 0, 0, 1'b0, 0);   // mul
    do_instr(5'b01111, 0, 0, 1'b0, 0);   // div
    do_instr(5'b11000, 0, 0, 1'b0, 0);   // mfhi
    do_instr(5'b11001, 0, 0, 1'b0, 0);   // mflo
    do_instr(5'b11111, 0, 0, 1'b0, 0);   // illegal
    do_instr(5'b10001, 0, 0, 1'b0, 0);   // illegal
    do_instr(5'b11011, 0, 0, 1'b0, 0);   // halt
    do_reset();
    do_instr(5'b00000, 0, 3, 1'b0, 5);   // ld aborted in T4
    do_reset();
    do_instr(5'b00010, 1, 0, 1'b1, 0);   // st with memory stuck
    do_reset();
    do_instr(5'b11010, 0, 0, 1'b0, 0);
    @(negedge clk); #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control FSM that drives the CPU datapath's bus-select, register-enable, ALU-opcode and memory strobes.
- Runs the fetch / decode / execute T-step sequence for each instruction and handshakes with memory through mem_rdy.
- Sits beside the datapath; takes IR[31:27] and drives every "out"/"in" control line plus run/halt status.

Parameters:
- MEM_WAIT_MAX, 15: maximum idle cycles waiting for mem_rdy before a bus error.
- OP_ADD, 5'b00011: ALU operation code used for effective-address and immediate addition.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset; synchronous, active-low
- ir_op  in  5  IR[31:27] opcode
- mem_rdy  in  1  memory completes the current Read/Write this cycle
- PCout, ZHighout, Zlowout, HIout, LOout, MDRout, Cout, BAout  out  1 each  bus-source selects (one-hot or none)
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and GP-register enable/drive
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, IncPC  out  1 each  register load strobes
- Read, Write  out  1 each  memory strobes
- operation  out  5  ALU opcode
- run  out  1  high while executing
- mem_err  out  1  sticky, set on memory timeout
- illegal_op  out  1  one-cycle pulse on an undecoded opcode

Behaviour:
- Reset (clr=0 at a clk edge): state=T0, wait counter=0, run=1, mem_err=0. All strobes are combinational from state and are 0 in reset except as listed for T0.
- Reset mid-instruction aborts it immediately; no partial writes occur after the reset edge.
- States: T0, T1, T2, T3..T7, HALT. Strobes are Moore outputs of the state plus latched ir_op. ir_op is sampled into a latched opcode at the end of T2.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, ZLOin.
  - T1: Zlowout, PCin, Read, MDRin. Hold in T1 until mem_rdy=1.
  - T2: MDRout, IRin.
- Execute sequences. Each ends by returning to T0 on the next cycle.
  - R-ALU (00011 to 01011): T3 Grb,Rout,Yin; T4 Grc,Rout,operation=op,ZLOin; T5 Zlowout,Gra,Rin.
  - I-ALU addi/andi/ori (01100 to 01110): T3 Grb,Rout,Yin; T4 Cout,operation=op,ZLOin; T5 Zlowout,Gra,Rin.
  - ldi (00001): T3 Grb,BAout,Yin; T4 Cout,OP_ADD,ZLOin; T5 Zlowout,Gra,Rin.
  - ld (00000): T3 and T4 as ldi; T5 Zlowout,MARin; T6 Read,MDRin (hold until mem_rdy); T7 MDRout,Gra,Rin.
  - st (00010): T3 and T4 as ldi; T5 Zlowout,MARin; T6 Gra,Rout,MDRin; T7 Write (hold until mem_rdy).
  - div/mul (01111/10000): T3 Gra,Rout,Yin; T4 Grb,Rout,operation=op,ZLOin,ZHIin; T5 Zlowout,LOin; T6 ZHighout,HIin.
  - mfhi/mflo (11000/11001): T3 HIout or LOout, Gra, Rin.
  - nop (11010): T3 no strobes.
  - halt (11011): T3 goes to HALT. In HALT, run=0 and all strobes are 0 until reset.
  - Any other opcode: illegal_op pulses in T3, then behaves as nop.
- operation=0 in every state not listed above.
- Memory wait rules:
  - The counter increments each cycle spent in a Read/Write state with mem_rdy=0, and clears on leaving that state.
  - If the counter reaches MEM_WAIT_MAX with mem_rdy still 0: set mem_err and go to HALT.
  - If mem_rdy=1 arrives on the same cycle the counter hits the limit, the access completes and no error is raised.
- Invariant: at most one bus-source select is high in any cycle; assertion required.
- Fetch latency is 3 cycles with zero-wait memory. Instruction cycles: R-ALU 6, ld/st 8, mfhi 4.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - the opcode localparams (LD, LDI, ST, ADD..SHL, ADDI, ANDI, ORI, DIV, MUL, MFHI, MFLO, NOP, HALT);
  - the state enum (T0..T7, HALT);
  - OP_ADD.
- One sub-module is natural: control_decode, the combinational state-plus-opcode to strobe-vector mapping. The FSM and wait counter stay in the top block.

Test Plan:
- Reset and fetch: clr=0 for 2 cycles, then 1, mem_rdy=1, ir_op=11010 -> T0 has PCout=MARin=IncPC=ZLOin=1; T2 has IRin=1; back to T0 after 4 cycles total.
- add (ir_op=00011) -> T4 shows Grc=Rout=ZLOin=1 with operation=00011; T5 shows Zlowout=Gra=Rin=1; 6 cycles total.
- ld with mem_rdy delayed 3 cycles in T6 -> Read=MDRin held for 4 cycles; T7 shows MDRout=Gra=Rin; no mem_err.
- st with mem_rdy stuck at 0 in T7 -> mem_err=1 after 15 wait cycles; run=0; all strobes 0 thereafter.
- mul (10000) -> T4 has ZLOin=ZHIin=1; T5 has LOin=1; T6 has HIin=1.
- ir_op=11111 -> illegal_op high for exactly 1 cycle in T3, then T0. halt (11011) -> run=0 until clr pulse, then T0.
